sram_port_arbiter: RTL and testbench



---
 rtl/sram_port_arbiter_if.sv | 43 ++++
 rtl/sram_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the SRAM port arbiter and its clients / SRAM controller.
// The master side is the client/controller environment, the slave side is
// the arbiter itself.
//
// Handshake: there is no valid/ready pair here. A loader asserts Req[i] and
// may only expect its write strobe to be accepted while Grant[i] is high and
// the arbiter is past its one-cycle setup (SRAM_we_n follows Client_we_n[i]
// only then). Ownership lasts until Req[i] drops or the inactivity timeout
// releases it.
interface sram_port_arbiter_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16
);
    localparam int OWN_W = (NUM_CLIENTS > 2) ? $clog2(NUM_CLIENTS) : 1;

    logic [NUM_CLIENTS-1:0]        Req;
    logic [NUM_CLIENTS*ADDR_W-1:0] Client_address;
    logic [NUM_CLIENTS*DATA_W-1:0] Client_wdata;
    logic [NUM_CLIENTS-1:0]        Client_we_n;

    logic [NUM_CLIENTS-1:0]        Grant;
    logic [OWN_W-1:0]              Owner;
    logic                          Display_enable;
    logic                          Timeout_pulse;
    logic [ADDR_W-1:0]             SRAM_address;
    logic [DATA_W-1:0]             SRAM_write_data;
    logic                          SRAM_we_n;
    logic [ADDR_W-1:0]             Write_count;
    logic [1:0]                    state_dbg;

    modport master (
        output Req, Client_address, Client_wdata, Client_we_n,
        input  Grant, Owner, Display_enable, Timeout_pulse,
        input  SRAM_address, SRAM_write_data, SRAM_we_n, Write_count, state_dbg
    );

    modport slave (
        input  Req, Client_address, Client_wdata, Client_we_n,
        output Grant, Owner, Display_enable, Timeout_pulse,
        output SRAM_address, SRAM_write_data, SRAM_we_n, Write_count, state_dbg
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// SRAM port arbiter: the display client owns the SRAM port by default; loader
// clients request exclusive ownership, chosen round-robin, and keep it until
// they drop Req or stay idle (after having written) for TIMEOUT_CYCLES.
// Optional feature macro: ARB_WRITE_COUNT_EN (per-grant write counter).
// The FSM state is exposed on bus.state_dbg.
module sram_port_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int DISPLAY_CLIENT = 0
) (
    input  logic Clock,
    input  logic Reset,
    sram_port_arbiter_if.slave bus
);
    localparam int OWN_W = (NUM_CLIENTS > 2) ? $clog2(NUM_CLIENTS) : 1;
    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]    T_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [OWN_W-1:0] DISP  = OWN_W'(DISPLAY_CLIENT);
    localparam logic [OWN_W-1:0] LAST  = OWN_W'(NUM_CLIENTS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_OWNED   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [OWN_W-1:0]       owner_q, owner_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic                   disp_q, disp_d;
    logic                   pulse_q, pulse_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   wrote_q, wrote_d;
    logic [OWN_W-1:0]       rr_q, rr_d;

    logic [NUM_CLIENTS-1:0] req_eff;
    logic                   pick_found;
    logic [OWN_W-1:0]       pick_idx;
    logic                   owner_req;
    logic                   owner_we_n;
    logic                   owner_write;
    logic                   timeout_hit;
    logic [OWN_W-1:0]       rr_next;

    // The display never requests; its Req bit is masked out of arbitration.
    always_comb begin
        req_eff                 = bus.Req;
        req_eff[DISPLAY_CLIENT] = 1'b0;
    end

    // Round-robin pick: first requesting loader at or after rr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (!pick_found && req_eff[(int'(rr_q) + k) % NUM_CLIENTS]) begin
                pick_found = 1'b1;
                pick_idx   = OWN_W'((int'(rr_q) + k) % NUM_CLIENTS);
            end
        end
    end

    assign owner_req   = bus.Req[owner_q];
    assign owner_we_n  = bus.Client_we_n[owner_q];
    assign owner_write = (state_q == S_OWNED) && !owner_we_n;
    // Only a loader that has written at least once can be timed out.
    assign timeout_hit = (timer_q == T_MAX) && wrote_q;
    assign rr_next     = (owner_q == LAST) ? '0 : owner_q + 1'b1;

    // Next-state and next-output logic of the ownership FSM.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grant_d = grant_q;
        disp_d  = disp_q;
        pulse_d = 1'b0;
        timer_d = timer_q;
        wrote_d = wrote_q;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    disp_d            = 1'b0;
                    timer_d           = '0;
                    wrote_d           = 1'b0;
                    state_d           = S_GRANT;
                end
            end
            S_GRANT: begin
                // Address already follows the new owner; writes stay blocked.
                state_d = S_OWNED;
            end
            S_OWNED: begin
                if (owner_write) begin
                    timer_d = '0;
                    wrote_d = 1'b1;
                end else if (timer_q != T_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
                if (!owner_req || timeout_hit) begin
                    grant_d = '0;
                    rr_d    = rr_next;
                    // A Req drop wins over a coincident timeout.
                    pulse_d = owner_req;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                owner_d = DISP;
                disp_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and ownership registers; reset hands the port back to the display.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            owner_q <= DISP;
            grant_q <= '0;
            disp_q  <= 1'b1;
            pulse_q <= 1'b0;
            timer_q <= '0;
            wrote_q <= 1'b0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            disp_q  <= disp_d;
            pulse_q <= pulse_d;
            timer_q <= timer_d;
            wrote_q <= wrote_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.Grant           = grant_q;
    assign bus.Owner           = owner_q;
    assign bus.Display_enable  = disp_q;
    assign bus.Timeout_pulse   = pulse_q;
    assign bus.state_dbg       = state_q;
    assign bus.SRAM_address    = bus.Client_address[int'(owner_q)*ADDR_W +: ADDR_W];
    assign bus.SRAM_write_data = bus.Client_wdata[int'(owner_q)*DATA_W +: DATA_W];
    assign bus.SRAM_we_n       = (state_q == S_OWNED) ? owner_we_n : 1'b1;

`ifdef ARB_WRITE_COUNT_EN
    logic [ADDR_W-1:0] wcount_q;

    // Writes accepted in the current grant; holds after release.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wcount_q <= '0;
        end else if (state_q == S_IDLE && pick_found) begin
            wcount_q <= '0;
        end else if (owner_write) begin
            wcount_q <= wcount_q + 1'b1;
        end
    end

    assign bus.Write_count = wcount_q;
`else
    assign bus.Write_count = '0;
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: a vector table for the basic hand-over,
// hand-written sequences for timeout, no-timeout, drop/timeout collision,
// write count, rr wrap and async reset, then randomized traffic against a
// behavioural model.
module tb_sram_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int TO = 100;
    localparam int OW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    sram_port_arbiter_if #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) bus();

    sram_port_arbiter #(
        .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW),
        .TIMEOUT_CYCLES(TO), .DISPLAY_CLIENT(0)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus(bus)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver ----------------
    logic [AW-1:0] c_addr[N];
    logic [DW-1:0] c_data[N];
    logic [N-1:0]  c_we_n;
    logic [N-1:0]  c_req;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.Client_address[i*AW +: AW] = c_addr[i];
            bus.Client_wdata[i*DW +: DW]   = c_data[i];
        end
        bus.Client_we_n = c_we_n;
        bus.Req         = c_req;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [OW-1:0] exp_q[$];
    logic [N-1:0]  prev_grant;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_loader: loader currently holding the port, -1 when the display has it.
    // m_cyc: cycles since the grant started (1 = setup cycle, writes blocked).
    // m_rel: the grant has ended; the port goes back to the display next cycle.
    // m_idle: consecutive owned cycles without a write, saturating at TO-1.
    int m_loader, m_cyc, m_idle, m_rr, m_wcount;
    bit m_rel, m_to, m_wrote;

    task automatic m_reset();
        m_loader = -1; m_cyc = 0; m_idle = 0; m_rr = 0; m_wcount = 0;
        m_rel = 0; m_to = 0; m_wrote = 0;
    endtask

    task automatic m_step();
        if (m_loader < 0) begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_rr + k) % N;
                if (idx != 0 && c_req[idx]) begin
                    m_loader = idx; m_cyc = 1; m_idle = 0; m_wrote = 0; m_wcount = 0;
                    exp_q.push_back(OW'(idx));
                    break;
                end
            end
        end else if (m_rel) begin
            m_loader = -1; m_rel = 0; m_to = 0;
        end else if (m_cyc == 1) begin
            m_cyc = 2;
        end else begin
            bit wr;
            bit drop;
            bit tout;
            wr   = !c_we_n[m_loader];
            drop = !c_req[m_loader];
            tout = m_wrote && (m_idle == TO - 1);
            if (wr) m_wcount = (m_wcount + 1) % (1 << AW);
            if (drop || tout) begin
                m_rel = 1; m_to = !drop; m_rr = (m_loader + 1) % N;
            end
            m_idle  = wr ? 0 : ((m_idle < TO - 1) ? m_idle + 1 : m_idle);
            m_wrote = m_wrote | wr;
        end
    endtask

    task automatic m_check();
        int   eo;
        logic [N-1:0] eg;
        logic ewe, ed, eto;
        int   gi;
        if (m_loader < 0) begin
            eo = 0; eg = '0; ewe = 1'b1; ed = 1'b1; eto = 1'b0;
        end else if (m_rel) begin
            eo = m_loader; eg = '0; ewe = 1'b1; ed = 1'b0; eto = m_to;
        end else begin
            eo = m_loader; eg = N'(1 << m_loader); ed = 1'b0; eto = 1'b0;
            ewe = (m_cyc == 1) ? 1'b1 : c_we_n[m_loader];
        end
        chk("rnd_grant", bus.Grant, eg);
        chk("rnd_owner", bus.Owner, eo);
        chk("rnd_display_enable", bus.Display_enable, ed);
        chk("rnd_timeout_pulse", bus.Timeout_pulse, eto);
        chk("rnd_sram_we_n", bus.SRAM_we_n, ewe);
        chk("rnd_sram_address", bus.SRAM_address, c_addr[eo]);
        chk("rnd_sram_wdata", bus.SRAM_write_data, c_data[eo]);
`ifdef ARB_WRITE_COUNT_EN
        chk("rnd_write_count", bus.Write_count, m_wcount);
`else
        chk("rnd_write_count", bus.Write_count, 0);
`endif
        if (bus.Grant != '0 && prev_grant == '0) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (bus.Grant[i]) gi = i;
            if (exp_q.size() == 0) chk("grant_order_empty", 1, 0);
            else chk("grant_order", gi, exp_q.pop_front());
        end
        prev_grant = bus.Grant;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  we_n;
        logic [N-1:0]  grant;
        logic          we;
        logic          disp;
        logic [OW-1:0] owner;
        logic          to;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n_rel;
        bit any_to;
        bit any_rel;

        tbl[0]  = '{4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0};
        tbl[1]  = '{4'b0110, 4'b1101, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0};
        tbl[2]  = '{4'b0110, 4'b1101, 4'b0010, 1'b1, 1'b0, 2'd1, 1'b0};
        tbl[3]  = '{4'b0110, 4'b1101, 4'b0010, 1'b0, 1'b0, 2'd1, 1'b0};
        tbl[4]  = '{4'b0110, 4'b1101, 4'b0010, 1'b0, 1'b0, 2'd1, 1'b0};
        tbl[5]  = '{4'b0100, 4'b1101, 4'b0010, 1'b0, 1'b0, 2'd1, 1'b0};
        tbl[6]  = '{4'b0100, 4'b1101, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0};
        tbl[7]  = '{4'b0100, 4'b1101, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0};
        tbl[8]  = '{4'b0100, 4'b1101, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b0};
        tbl[9]  = '{4'b0100, 4'b1111, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b0};
        tbl[10] = '{4'b0000, 4'b1111, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b0};
        tbl[11] = '{4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0};
        tbl[12] = '{4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0};

        for (int i = 0; i < N; i++) begin
            c_addr[i] = AW'(18'h1000 * (i + 1) + i);
            c_data[i] = DW'(16'h0a00 + 16'h0011 * i);
        end
        c_we_n = '1;
        c_req  = '0;
        drive();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic hand-over: 1 and 2 request together, 1 wins, then 2.
        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            c_req  = tbl[v].req;
            c_we_n = tbl[v].we_n;
            drive();
            #1;
            chk($sformatf("tbl%0d_grant", v), bus.Grant, tbl[v].grant);
            chk($sformatf("tbl%0d_we_n", v), bus.SRAM_we_n, tbl[v].we);
            chk($sformatf("tbl%0d_disp", v), bus.Display_enable, tbl[v].disp);
            chk($sformatf("tbl%0d_owner", v), bus.Owner, tbl[v].owner);
            chk($sformatf("tbl%0d_to", v), bus.Timeout_pulse, tbl[v].to);
            chk($sformatf("tbl%0d_addr", v), bus.SRAM_address, c_addr[tbl[v].owner]);
        end

        // Timeout: one write, then idle while holding Req (rr=3 -> client1).
        c_req = 4'b0010; c_we_n = 4'b1111; drive();
        tick();
        chk("to_grant", bus.Grant, 4'b0010);
        tick();
        c_we_n[1] = 1'b0; drive();
        tick();
        c_we_n = 4'b1111; drive();
        n_rel = 0;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (bus.Timeout_pulse) begin
                n_rel = n;
                break;
            end
        end
        chk("to_latency", n_rel, 100);
        chk("to_grant_cleared", bus.Grant, 4'b0000);
        c_req = 4'b0000; drive();
        tick();
        chk("to_pulse_width", bus.Timeout_pulse, 0);
        chk("to_display_back", bus.Display_enable, 1);

        // Never writes: never timed out (rr=2 -> client1).
        c_req = 4'b0010; drive();
        tick();
        any_to = 0; any_rel = 0;
        for (int n = 0; n < 500; n++) begin
            tick();
            any_to  = any_to | bus.Timeout_pulse;
            any_rel = any_rel | (bus.Grant == 4'b0000);
        end
        chk("nowrite_no_pulse", any_to, 0);
        chk("nowrite_never_released", any_rel, 0);
        chk("nowrite_still_granted", bus.Grant, 4'b0010);
        c_req = 4'b0000; drive();
        tick(); tick();
        chk("nowrite_display_back", bus.Display_enable, 1);

        // Req drop in the same cycle the timeout would fire.
        c_req = 4'b0010; drive();
        tick(); tick();
        c_we_n[1] = 1'b0; drive();
        tick();
        c_we_n = 4'b1111; drive();
        for (int n = 1; n <= 99; n++) tick();
        chk("coll_still_granted", bus.Grant, 4'b0010);
        c_req = 4'b0000; drive();
        tick();
        chk("coll_released", bus.Grant, 4'b0000);
        chk("coll_no_pulse", bus.Timeout_pulse, 0);
        tick();
        chk("coll_display_back", bus.Display_enable, 1);

        // Five writes by client3 (rr=2), then release; Write_count holds.
        c_req = 4'b1000; drive();
        tick();
        chk("wc_grant3", bus.Grant, 4'b1000);
        tick();
        c_we_n[3] = 1'b0; drive();
        repeat (5) tick();
        c_we_n = 4'b1111; c_req = 4'b0000; drive();
        tick(); tick(); tick();
`ifdef ARB_WRITE_COUNT_EN
        chk("wc_count_after_release", bus.Write_count, 5);
`else
        chk("wc_count_tied", bus.Write_count, 0);
`endif
        chk("wc_owner_display", bus.Owner, 0);

        // rr wrapped to 0 after client3: client1 beats client3.
        c_req = 4'b1010; drive();
        tick();
        chk("rr_wrap_grant", bus.Grant, 4'b0010);
        c_req = 4'b0000; drive();
        tick(); tick(); tick();

        // Async reset in the middle of a writing grant (rr=2 -> client3).
        c_req = 4'b1000; drive();
        tick(); tick();
        c_we_n[3] = 1'b0; drive();
        repeat (5) tick();
        chk("rst_writing", bus.SRAM_we_n, 0);
        rst = 1'b1;
        #1;
        chk("rst_we_n", bus.SRAM_we_n, 1);
        chk("rst_grant", bus.Grant, 4'b0000);
        chk("rst_display", bus.Display_enable, 1);
        chk("rst_owner", bus.Owner, 0);
        c_req = 4'b0000; c_we_n = 4'b1111; drive();
        tick();
        rst = 1'b0;

        // Randomized traffic against the model.
        m_reset();
        exp_q.delete();
        prev_grant = '0;
        begin
            int pct;
            pct = 40;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                @(negedge clk);
                if (cyc % 250 == 0) begin
                    case ($urandom_range(0, 3))
                        0: pct = 0;
                        1: pct = 3;
                        2: pct = 40;
                        default: pct = 90;
                    endcase
                end
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 15) == 0) c_req[i] = ~c_req[i];
                    c_we_n[i] = ($urandom_range(0, 99) < pct) ? 1'b0 : 1'b1;
                    c_addr[i] = AW'($urandom);
                    c_data[i] = DW'($urandom);
                end
                drive();
                #1;
                m_check();
                @(posedge clk);
                m_step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
